clk_div_bank: RTL
=================

Name: clk_div_bank

Overview:
- Parametrised, multi-channel successor to the fixed-ratio clock manager.
- Generates NUM_CH independent divided clocks and matching single-cycle tick strobes from one master clock.
- Each channel has a runtime-programmable divisor, per-channel enable, and glitch-free divisor update.
- A global sync strobe phase-aligns all running channels.
- Sits between the board oscillator input and the DUT/ADC/system clock consumers.
- Consumers use tick_o as a clock enable in the clk_in domain. clk_o is routed to pins or clock buffers.

Parameters:
- NUM_CH, 3: number of divider channels (1..16).
- DIV_W, 8: divisor width in bits.
- DEF_DIV, 4: divisor loaded into every channel at reset; must be >= 2.

Ports:
- clk_in  input  1  master clock; all logic is on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- div_i  input  NUM_CH*DIV_W  divisor per channel; channel i uses bits [i*DIV_W +: DIV_W].
- div_load  input  NUM_CH  when high for one cycle, captures div_i slice i into channel i's pending register.
- ch_en  input  NUM_CH  per-channel run request.
- sync  input  1  one-cycle global phase-realign strobe.
- clk_o  output  NUM_CH  divided clock per channel.
- tick_o  output  NUM_CH  one-cycle pulse coinciding with the first high cycle of each clk_o period.
- active_o  output  NUM_CH  channel is running.

Behaviour:
- One clock (clk_in). Reset is asynchronous and active-high (rst).
- Per-channel state: cnt[DIV_W], cur_div, pend_div, pend_vld, run.
- Reset values: clk_o=0, tick_o=0, active_o=0, cnt=0, cur_div=DEF_DIV, pend_vld=0, run=0.
- Reset mid-operation aborts all channels immediately; no partial period is completed.
- Effective divisor D = max(cur_div, 2). Values 0 and 1 are treated as 2.
- Period is D cycles. H = ceil(D/2).
- clk_o is high in the cycles where cnt < H and low otherwise. Example: D=5 gives high for 3 cycles, low for 2.
- tick_o = run AND cnt==0.
- All outputs come straight from flops. There is no combinational path from any input to any output.
- Counter: while run, cnt increments each cycle and wraps from D-1 to 0.
- div_load[i]: pend_div <= slice, pend_vld <= 1.
- A load while pend_vld is already set overwrites the pending value (last load wins).
- Pending divisor application:
  - It is applied on the wrap cycle (cnt==D-1 -> 0): cur_div <= pend_div, pend_vld <= 0.
  - The new D governs the period starting at cnt=0.
  - A running period is never shortened or stretched, so there are no glitches or runt pulses.
- A load and a wrap in the same cycle: the wrap applies the old pending value (if any), and the new load becomes pending.
- Idle channel (run=0): a pending divisor is applied on the next cycle.
- Enable, idle to running: ch_en rises while run=0.
  - Next cycle: run=1, cnt=0, clk_o=1, tick_o=1, active_o=1.
  - Latency from ch_en high to first tick is 1 cycle.
- Disable: ch_en low while run=1.
  - The channel completes its current period.
  - On the wrap cycle it sets run=0, cnt=0, active_o=0, and clk_o stays 0.
  - If ch_en returns high before the wrap, the channel keeps running with no disturbance.
- sync (priority over wrap and enable logic):
  - In the cycle after sync, every channel with ch_en=1 has cnt=0, run=1, clk_o=1, tick_o=1, and pending divisors applied.
  - Channels with ch_en=0 are unaffected.
  - sync and div_load in the same cycle: the newly loaded value is applied by that sync.
- Channels are fully independent apart from sync.

Test Plan:
- Reset then ch_en=3'b111, with DEF_DIV=4 -> each clk_o runs 2 high / 2 low, first high 1 cycle after ch_en; tick_o every 4 cycles; active_o=3'b111.
- Channel 0 running at D=4; div_load with 10 mid-period (cnt=1) -> cycles at cnt 2,3 complete; next period 10 cycles (5 high / 5 low); no pulse shorter than 2 cycles.
- Odd and degenerate divisors: load 5 -> 3 high / 2 low; load 1 and 0 -> behaves as D=2 (1 high / 1 low).
- Channel 1 at D=8; drop ch_en at cnt=2 -> clk_o completes the period, active_o falls at the wrap, clk_o held 0; re-raise ch_en -> tick 1 cycle later.
- Channels at D=4, 6, 10 running out of phase; pulse sync -> next cycle all three have tick_o=1 and clk_o=1 simultaneously; the following ticks occur 4, 6 and 10 cycles later.
- Assert rst asynchronously mid-period on all channels -> all outputs 0 immediately; after release and ch_en=1, D returns to DEF_DIV=4 regardless of the prior load.

Source files
------------

// File: rtl/clk_div_bank.sv
// Multi-channel programmable clock divider: per-channel divided clock, tick strobe and
// run status, with divisor changes deferred to period boundaries and a global phase sync.
module clk_div_bank #(
    parameter int NUM_CH  = 3,
    parameter int DIV_W   = 8,
    parameter int DEF_DIV = 4
) (
    input  logic                    clk_in,
    input  logic                    rst,
    input  logic [NUM_CH*DIV_W-1:0] div_i,
    input  logic [NUM_CH-1:0]       div_load,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic                    sync,
    output logic [NUM_CH-1:0]       clk_o,
    output logic [NUM_CH-1:0]       tick_o,
    output logic [NUM_CH-1:0]       active_o
);

    function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
        return (d < DIV_W'(2)) ? DIV_W'(2) : d;
    endfunction

    for (genvar g = 0; g < NUM_CH; g++) begin : gen_ch
        logic [DIV_W-1:0] cnt_q, cur_q, pend_q;
        logic             pvld_q, run_q;
        logic             clk_q, tick_q, act_q;

        logic [DIV_W-1:0] cnt_d, cur_d, pend_d;
        logic             pvld_d, run_d;
        logic [DIV_W-1:0] slice, cur_apply, d_now, d_next;
        logic [DIV_W:0]   half_next;
        logic             wrap;

        assign slice = div_i[g*DIV_W +: DIV_W];

        always_comb begin
            cnt_d     = cnt_q;
            cur_d     = cur_q;
            pend_d    = pend_q;
            pvld_d    = pvld_q;
            run_d     = run_q;
            d_now     = eff_div(cur_q);
            wrap      = run_q && (cnt_q == d_now - DIV_W'(1));
            cur_apply = pvld_q ? pend_q : cur_q;

            if (sync && ch_en[g]) begin
                // a load coinciding with sync is consumed directly by the realignment
                run_d  = 1'b1;
                cnt_d  = '0;
                cur_d  = div_load[g] ? slice : cur_apply;
                pvld_d = 1'b0;
                if (div_load[g])
                    pend_d = slice;
            end else begin
                if (!run_q || wrap) begin
                    cur_d  = cur_apply;
                    pvld_d = 1'b0;
                    cnt_d  = '0;
                    run_d  = ch_en[g];
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
                if (div_load[g]) begin
                    pend_d = slice;
                    pvld_d = 1'b1;
                end
            end

            d_next    = eff_div(cur_d);
            half_next = ({1'b0, d_next} + (DIV_W+1)'(1)) >> 1;
        end

        // outputs are computed from next state so they leave the bank straight from flops
        always_ff @(posedge clk_in or posedge rst) begin
            if (rst) begin
                cnt_q  <= '0;
                cur_q  <= DIV_W'(DEF_DIV);
                pend_q <= DIV_W'(DEF_DIV);
                pvld_q <= 1'b0;
                run_q  <= 1'b0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
                act_q  <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                cur_q  <= cur_d;
                pend_q <= pend_d;
                pvld_q <= pvld_d;
                run_q  <= run_d;
                clk_q  <= run_d && ({1'b0, cnt_d} < half_next);
                tick_q <= run_d && (cnt_d == '0);
                act_q  <= run_d;
            end
        end

        assign clk_o[g]    = clk_q;
        assign tick_o[g]   = tick_q;
        assign active_o[g] = act_q;
    end

endmodule
